crc_share_ctrl: RTL

- Controller that time-shares one combinational CRC divider (payload BW bits plus CRC_BW appended bits in, CRC_BW-bit remainder out) between two requesters.
- Each requester submits a full frame with a mode: GEN computes the CRC over the payload; CHECK verifies a received CRC.
- Round-robin arbitration, registered operand and result, response handshake with backpressure, saturating statistics counters.
- Sits between the TX framer (GEN) and RX deframer (CHECK) and the shared CRC datapath.

---
 rtl/crc_pkg.sv | 18 +
 rtl/crc_divider.sv | 30 +++
 rtl/crc_rr_arb.sv | 21 ++
 rtl/crc_share_ctrl.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/crc_pkg.sv
// Shared constants and types for the shared-CRC controller.
//   MODE_GEN / MODE_CHECK : request mode encoding
//   DEFAULT_DIVISOR       : x^8+x^2+x+1 without the implicit MSB
//   state_e               : controller FSM encoding
package crc_pkg;

  localparam logic MODE_GEN   = 1'b0;
  localparam logic MODE_CHECK = 1'b1;

  localparam logic [7:0] DEFAULT_DIVISOR = 8'h07;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/crc_divider.sv
// Combinational polynomial divider: remainder of data_i(x) mod (x^CRC_BW + DIVISOR).
//   data_i : BW payload bits followed by CRC_BW appended bits, MSB first
//   rem_o  : CRC_BW-bit remainder
module crc_divider #(
  parameter int unsigned BW      = 40,
  parameter int unsigned CRC_BW  = 8,
  parameter logic [CRC_BW-1:0] DIVISOR = 8'h07
) (
  input  logic [BW+CRC_BW-1:0] data_i,
  output logic [CRC_BW-1:0]    rem_o
);

  localparam int unsigned DW = BW + CRC_BW;

  logic [CRC_BW-1:0] rem;
  logic              msb;

  // Shift each operand bit into the remainder; reduce when a set bit falls off the top.
  always_comb begin
    rem = '0;
    msb = 1'b0;
    for (int i = DW - 1; i >= 0; i--) begin
      msb = rem[CRC_BW-1];
      rem = {rem[CRC_BW-2:0], data_i[i]};
      if (msb) rem = rem ^ DIVISOR;
    end
    rem_o = rem;
  end

endmodule

// File: rtl/crc_rr_arb.sv
// Two-way round-robin picker.
//   valid_i[1:0] : request lines
//   ptr_i        : preferred requester when both are valid
//   grant_o[1:0] : one-hot grant, zero when nothing is valid
module crc_rr_arb (
  input  logic [1:0] valid_i,
  input  logic       ptr_i,
  output logic [1:0] grant_o
);

  always_comb begin
    grant_o = 2'b00;
    case (valid_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = ptr_i ? 2'b10 : 2'b01;
      default: grant_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/crc_share_ctrl.sv
// Time-shares one combinational CRC divider between two requesters.
//   clk, rst                 : clock, synchronous active-high reset
//   reqN_valid/ready/mode/data : frame request (mode 0=GEN, 1=CHECK)
//   rsp_valid/ready/id/mode/crc/pass : registered result with backpressure
//   busy                     : controller not idle
//   stat_clr, frame_cnt, fail_cnt : saturating statistics
module crc_share_ctrl
  import crc_pkg::*;
#(
  parameter int unsigned BW      = 40,
  parameter int unsigned CRC_BW  = 8,
  parameter logic [CRC_BW-1:0] DIVISOR = CRC_BW'(DEFAULT_DIVISOR),
  parameter int unsigned CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req0_valid,
  output logic                   req0_ready,
  input  logic                   req0_mode,
  input  logic [BW+CRC_BW-1:0]   req0_data,
  input  logic                   req1_valid,
  output logic                   req1_ready,
  input  logic                   req1_mode,
  input  logic [BW+CRC_BW-1:0]   req1_data,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic                   rsp_id,
  output logic                   rsp_mode,
  output logic [CRC_BW-1:0]      rsp_crc,
  output logic                   rsp_pass,
  output logic                   busy,
  input  logic                   stat_clr,
  output logic [CNT_W-1:0]       frame_cnt,
  output logic [CNT_W-1:0]       fail_cnt
);

  localparam int unsigned DW = BW + CRC_BW;

  state_e            state_q;
  logic              rr_ptr_q;
  logic              op_id_q;
  logic              op_mode_q;
  logic [DW-1:0]     op_data_q;

  logic [1:0]        grant;
  logic              in_idle;
  logic              accept;
  logic              sel_id;
  logic              sel_mode;
  logic [DW-1:0]     sel_data;
  logic [DW-1:0]     operand;
  logic [CRC_BW-1:0] rem;
  logic              check_fail;

  crc_rr_arb u_arb (
    .valid_i ({req1_valid, req0_valid}),
    .ptr_i   (rr_ptr_q),
    .grant_o (grant)
  );

  // Readys only in IDLE and never while reset is asserted.
  assign in_idle    = (state_q == ST_IDLE) && !rst;
  assign req0_ready = in_idle && grant[0];
  assign req1_ready = in_idle && grant[1];
  assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);

  assign sel_id   = grant[1];
  assign sel_mode = sel_id ? req1_mode : req0_mode;
  assign sel_data = sel_id ? req1_data : req0_data;

  // GEN divides payload*x^CRC_BW, so the appended field is forced to zero.
  assign operand = (sel_mode == MODE_GEN) ? {sel_data[DW-1:CRC_BW], {CRC_BW{1'b0}}}
                                          : sel_data;

  crc_divider #(
    .BW      (BW),
    .CRC_BW  (CRC_BW),
    .DIVISOR (DIVISOR)
  ) u_div (
    .data_i (op_data_q),
    .rem_o  (rem)
  );

  assign check_fail = (op_mode_q == MODE_CHECK) && (rem != '0);
  assign busy       = (state_q != ST_IDLE);

  // Control FSM: accept -> one compute cycle -> hold response until taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      rr_ptr_q  <= 1'b0;
      op_id_q   <= 1'b0;
      op_mode_q <= MODE_GEN;
      op_data_q <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_mode  <= 1'b0;
      rsp_crc   <= '0;
      rsp_pass  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            op_data_q <= operand;
            op_mode_q <= sel_mode;
            op_id_q   <= sel_id;
            state_q   <= ST_CALC;
          end
        end
        ST_CALC: begin
          rsp_crc   <= rem;
          rsp_pass  <= (op_mode_q == MODE_GEN) || (rem == '0);
          rsp_valid <= 1'b1;
          rsp_id    <= op_id_q;
          rsp_mode  <= op_mode_q;
          state_q   <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rr_ptr_q  <= ~op_id_q;
            state_q   <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Saturating statistics; clear wins over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      frame_cnt <= '0;
      fail_cnt  <= '0;
    end else begin
      if (accept && (frame_cnt != '1))
        frame_cnt <= frame_cnt + CNT_W'(1);
      if ((state_q == ST_CALC) && check_fail && (fail_cnt != '1))
        fail_cnt <= fail_cnt + CNT_W'(1);
    end
  end

endmodule
